// File: rtl/data_ram_ws_pkg.sv
// ============================================================================
//  Module : data_ram_ws_pkg
//  Brief  : Shared state encodings and counter width for the wait-state RAM.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package data_ram_ws_pkg;

    localparam int         c_CNT_W   = 4;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/data_ram_ws_bytelane.sv
// ============================================================================
//  Module : data_ram_ws_bytelane
//  Brief  : DEPTH x DATA_W storage split into byte lanes, synchronous read.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module data_ram_ws_bytelane #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [DATA_W/8-1:0]        sel,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    localparam int c_LANES = DATA_W / 8;

    generate
        for (genvar i = 0; i < c_LANES; i++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_q;

            // Storage has no reset so it maps onto RAM macros.
            always_ff @(posedge clk) begin
                if (we && sel[i]) begin
                    r_mem[idx] <= wdata[8*i +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= 8'd0;
                end else if (re) begin
                    r_q <= r_mem[idx];
                end
            end

            assign rdata[8*i +: 8] = r_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/data_ram_ws.sv
// ============================================================================
//  Module : data_ram_ws
//  Brief  : Byte-lane data RAM with WAIT_CYC wait states and a stall request.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module data_ram_ws
    import data_ram_ws_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  hold_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  ready_o,
    output logic                  stallreq
);

    localparam int                 c_LANES   = DATA_W / 8;
    localparam int                 c_IDX_W   = $clog2(DEPTH);
    localparam int                 c_OFF_W   = $clog2(c_LANES);
    localparam logic [c_CNT_W-1:0] c_WAIT_LD = c_CNT_W'(WAIT_CYC);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_we;
    logic [c_LANES-1:0]  r_sel;
    logic [DATA_W-1:0]   r_data;
    logic [c_IDX_W-1:0]  r_idx;

    logic [c_IDX_W-1:0]  w_idx_in;
    logic                w_commit;
    logic                w_use_in;
    logic                w_acc_we;
    logic [c_IDX_W-1:0]  w_acc_idx;
    logic [c_LANES-1:0]  w_acc_sel;
    logic [DATA_W-1:0]   w_acc_data;
    logic                w_unused_addr;

    // Upper address bits wrap; byte-offset bits are covered by sel.
    assign w_idx_in      = addr[c_OFF_W +: c_IDX_W];
    assign w_unused_addr = ^addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_data  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_ST_IDLE && ce) begin
                r_cnt  <= c_WAIT_LD;
                r_we   <= we;
                r_sel  <= sel;
                r_data <= data_i;
                r_idx  <= w_idx_in;
            end else if (r_state == c_ST_WAIT) begin
                r_cnt  <= r_cnt - c_ONE;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (ce) w_next = (WAIT_CYC == 0) ? c_ST_DONE : c_ST_WAIT;
            c_ST_WAIT: if (r_cnt <= c_ONE) w_next = c_ST_DONE;
            c_ST_DONE: if (!hold_i) w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        stallreq = 1'b0;
        ready_o  = 1'b0;
        case (r_state)
            c_ST_IDLE: stallreq = ce;
            c_ST_WAIT: stallreq = 1'b1;
            c_ST_DONE: ready_o  = 1'b1;
            default:   stallreq = 1'b0;
        endcase
    end

    // The RAM is touched only on the edge entering DONE; with no wait states
    // that edge is the accept edge, so the live inputs are used instead.
    assign w_commit   = !rst && (r_state != c_ST_DONE) && (w_next == c_ST_DONE);
    assign w_use_in   = (r_state == c_ST_IDLE);
    assign w_acc_we   = w_use_in ? we       : r_we;
    assign w_acc_idx  = w_use_in ? w_idx_in : r_idx;
    assign w_acc_sel  = w_use_in ? sel      : r_sel;
    assign w_acc_data = w_use_in ? data_i   : r_data;

    data_ram_ws_bytelane #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (w_commit & w_acc_we),
        .re     (w_commit & ~w_acc_we),
        .idx    (w_acc_idx),
        .sel    (w_acc_sel),
        .wdata  (w_acc_data),
        .rdata  (data_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_data_ram_ws.sv
// ============================================================================
//  Module : tb_data_ram_ws
//  Brief  : Directed bench for data_ram_ws with WAIT_CYC=2 and WAIT_CYC=0.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_data_ram_ws;

    logic        clk;
    logic        rst;
    logic [1:0]  ce_v, we_v, hold_v;
    logic [31:0] addr_v [2];
    logic [31:0] data_v [2];
    logic [3:0]  sel_v  [2];
    logic [31:0] dout   [2];
    logic [1:0]  rdy, stl;

    logic [31:0] model [2][1024];
    logic [31:0] exp_q [$];
    int          n_tests;
    int          n_fail;

    data_ram_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYC(2)) u_dut_a (
        .clk(clk), .rst(rst), .ce(ce_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .sel(sel_v[0]), .data_i(data_v[0]), .hold_i(hold_v[0]),
        .data_o(dout[0]), .ready_o(rdy[0]), .stallreq(stl[0])
    );

    data_ram_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYC(0)) u_dut_b (
        .clk(clk), .rst(rst), .ce(ce_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .sel(sel_v[1]), .data_i(data_v[1]), .hold_i(hold_v[1]),
        .data_o(dout[1]), .ready_o(rdy[1]), .stallreq(stl[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drive one access on DUT b starting at a sample point, follow it through
    // DONE (plus `hold` held cycles) and back to IDLE.
    task automatic access(input int b, input bit wr, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          input int hold, input string tag);
        int          lat;
        int          nst;
        int          wc;
        logic [31:0] v;
        logic [9:0]  wi;
        wc = (b == 0) ? 2 : 0;
        wi = a[11:2];
        ce_v[b] = 1'b1; we_v[b] = wr; addr_v[b] = a; sel_v[b] = s;
        data_v[b] = d; hold_v[b] = (hold > 0);
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) model[b][wi][i*8 +: 8] = d[i*8 +: 8];
        end else begin
            exp_q.push_back(model[b][wi]);
        end
        lat = 0;
        nst = 0;
        #1;
        while (!rdy[b] && lat < 40) begin
            if (stl[b]) nst++;
            step();
            lat++;
            // The request is latched; later input changes must be ignored.
            addr_v[b] = a ^ 32'h0000_0FF0; data_v[b] = ~d; sel_v[b] = ~s; we_v[b] = ~wr;
        end
        check({tag, "_latency"}, 32'(lat), 32'(wc + 1));
        check({tag, "_stall_cycles"}, 32'(nst), 32'(wc + 1));
        check({tag, "_done_stall"}, 32'(stl[b]), 32'd0);
        if (!wr) begin
            if (exp_q.size() == 0) begin
                check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
            end else begin
                v = exp_q.pop_front();
                check({tag, "_rdata"}, dout[b], v);
            end
        end
        v = dout[b];
        for (int k = 0; k < hold; k++) begin
            step();
            check({tag, "_hold_ready"}, 32'(rdy[b]), 32'd1);
            check({tag, "_hold_data"}, dout[b], v);
            check({tag, "_hold_stall"}, 32'(stl[b]), 32'd0);
        end
        ce_v[b] = 1'b0;
        hold_v[b] = 1'b0;
        step();
        check({tag, "_idle_ready"}, 32'(rdy[b]), 32'd0);
        check({tag, "_idle_stall"}, 32'(stl[b]), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        for (int b = 0; b < 2; b++) begin
            ce_v[b] = 1'b0; we_v[b] = 1'b0; hold_v[b] = 1'b0;
            addr_v[b] = '0; data_v[b] = '0; sel_v[b] = '0;
        end
        repeat (3) step();
        for (int b = 0; b < 2; b++) begin
            check("reset_data", dout[b], 32'd0);
            check("reset_ready", 32'(rdy[b]), 32'd0);
            check("reset_stall", 32'(stl[b]), 32'd0);
        end
        rst = 1'b0;
        step();

        // Full-word write then read back.
        access(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 0, "t1_wr");
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0, 0, "t1_rd");
        check("t1_const", dout[0], 32'hDEADBEEF);

        // Single-lane merge.
        access(0, 1'b1, 32'h20, 4'b1111, 32'h11223344, 0, "t2_pre");
        access(0, 1'b1, 32'h20, 4'b0010, 32'h0000AA00, 0, "t2_wr");
        access(0, 1'b0, 32'h20, 4'b0000, 32'h0, 0, "t2_rd");
        check("t2_const", dout[0], 32'h1122AA44);

        // Held DONE, then idle with ce low keeps data_o.
        access(0, 1'b0, 32'h20, 4'b1111, 32'h0, 4, "t3_hold");
        repeat (3) step();
        check("t3_idle_data", dout[0], 32'h1122AA44);
        check("t3_idle_stall", 32'(stl[0]), 32'd0);

        // Reset aborts a pending write.
        access(0, 1'b1, 32'h30, 4'b1111, 32'h5555AAAA, 0, "t4_pre");
        ce_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h30;
        sel_v[0] = 4'b1111; data_v[0] = 32'hFFFFFFFF;
        step();
        check("t4_wait_stall", 32'(stl[0]), 32'd1);
        rst = 1'b1;
        ce_v[0] = 1'b0;
        step();
        check("t4_rst_data", dout[0], 32'd0);
        check("t4_rst_ready", 32'(rdy[0]), 32'd0);
        check("t4_rst_stall", 32'(stl[0]), 32'd0);
        rst = 1'b0;
        step();
        access(0, 1'b0, 32'h30, 4'b1111, 32'h0, 0, "t4_rd");
        check("t4_const", dout[0], 32'h5555AAAA);

        // Address wrap past DEPTH words.
        access(0, 1'b1, 32'h1000, 4'b1111, 32'hCAFEF00D, 0, "t5_wr");
        access(0, 1'b0, 32'h0, 4'b1111, 32'h0, 0, "t5_rd");
        check("t5_const", dout[0], 32'hCAFEF00D);

        // sel=0 write changes nothing.
        access(0, 1'b1, 32'h10, 4'b0000, 32'h01020304, 0, "t7_wr");
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0, 0, "t7_rd");
        check("t7_const", dout[0], 32'hDEADBEEF);

        // Zero wait states: write then read.
        access(1, 1'b1, 32'h40, 4'b1111, 32'h12345678, 0, "t6_wr");
        access(1, 1'b0, 32'h40, 4'b1111, 32'h0, 0, "t6_rd");
        check("t6_const", dout[1], 32'h12345678);
        access(1, 1'b1, 32'h40, 4'b1000, 32'h9A000000, 1, "t6_wr2");
        access(1, 1'b0, 32'h40, 4'b1111, 32'h0, 0, "t6_rd2");
        v = dout[1];
        check("t6_const2", v, 32'h9A345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
